// File: rtl/wb_arbiter_pkg.sv
// Shared widths, write-port record and round-robin helper for the writeback arbiter.
// Defaults match the shared define.h header; a prior include of that header takes precedence.
`ifndef REG_NUM
`define REG_NUM 5
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef WB_REQ_NUM
`define WB_REQ_NUM 3
`endif

package wb_arbiter_pkg;
    localparam int REG_W          = `REG_NUM;
    localparam int DATA_W         = `COMMON_WIDTH;
    localparam int WB_REQ_DEFAULT = `WB_REQ_NUM;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_write_t;

    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction
endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin one-hot grant: first asserted request found searching ptr, ptr+1, ... mod N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);
    logic [PTR_W-1:0] sel;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one registered register-file write per cycle, round-robin among
// requesters; requests targeting rd=0 are accepted and dropped without using the port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_REQ = WB_REQ_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*REG_W-1:0]  req_rd,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [REG_W-1:0]        reg_write,
    output logic [DATA_W-1:0]       data_write
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] nz_req;
    logic [N_REQ-1:0] zero_req;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    wb_write_t        wr_q, wr_d;

    always_comb begin
        nz_req   = '0;
        zero_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            nz_req[i]   = req_valid[i] && (req_rd[i*REG_W +: REG_W] != '0);
            zero_req[i] = req_valid[i] && (req_rd[i*REG_W +: REG_W] == '0);
        end
    end

    rr_arbiter #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_rr (
        .req  (nz_req),
        .ptr  (ptr_q),
        .grant(grant)
    );

    // Masked in reset so no requester sees a transfer that the reset then discards.
    assign req_ready = rst ? '0 : (zero_req | grant);

    always_comb begin
        wr_d  = '0;
        ptr_d = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                wr_d.rd   = req_rd[i*REG_W +: REG_W];
                wr_d.data = req_data[i*DATA_W +: DATA_W];
                ptr_d     = PTR_W'(rr_next(i, N_REQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            ptr_q <= '0;
        end else begin
            wr_q  <= wr_d;
            ptr_q <= ptr_d;
        end
    end

    assign reg_write  = wr_q.rd;
    assign data_write = wr_q.data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter with a queue-based scoreboard.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N*REG_W-1:0]  req_rd;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic [REG_W-1:0]    reg_write;
    logic [DATA_W-1:0]   data_write;

    always #5 clk = ~clk;

    wb_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_write (reg_write),
        .data_write(data_write)
    );

    typedef struct {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    int          m_ptr    = 0;
    int          wait_cnt [N];
    logic [DATA_W-1:0] shadow [2**REG_W];
    bit          mon_on   = 1'b0;
    bit          done     = 1'b0;

    bit                pv  [N];
    logic [REG_W-1:0]  prd [N];
    logic [DATA_W-1:0] pd  [N];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N*REG_W-1:0] pack_rd(input int a0, input int a1, input int a2);
        return {REG_W'(a2), REG_W'(a1), REG_W'(a0)};
    endfunction

    function automatic logic [N*DATA_W-1:0] pack_d(input int a0, input int a1, input int a2);
        return {DATA_W'(a2), DATA_W'(a1), DATA_W'(a0)};
    endfunction

    // One clock of stimulus: drive, predict acceptance from the arbitration rules, queue the write.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*REG_W-1:0] rds,
                         input logic [N*DATA_W-1:0] ds, output logic [N-1:0] exp_rdy);
        exp_t e;
        int   g;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_rd    = rds;
        req_data  = ds;
        #1;
        check("ptr", 64'(dut.ptr_q), 64'(m_ptr));
        exp_rdy = '0;
        e.rd    = '0;
        e.data  = '0;
        g       = -1;
        if (!r) begin
            for (int i = 0; i < N; i++)
                if (v[i] && rds[i*REG_W +: REG_W] == '0) exp_rdy[i] = 1'b1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && v[j] && rds[j*REG_W +: REG_W] != '0) g = j;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                e.rd       = rds[g*REG_W +: REG_W];
                e.data     = ds[g*DATA_W +: DATA_W];
                m_ptr      = (g + 1) % N;
            end
        end else begin
            m_ptr = 0;
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (!r && v[i] && rds[i*REG_W +: REG_W] != '0) begin
                if (req_ready[i]) begin
                    check("starve_bound", 64'(wait_cnt[i] < N), 64'(1));
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                end
            end else begin
                wait_cnt[i] = 0;
            end
        end
        exp_q.push_back(e);
        mon_on = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reg_write", 64'(reg_write), 64'(e.rd));
                check("data_write", 64'(data_write), 64'(e.data));
                if (reg_write != '0) shadow[reg_write] = data_write;
            end else if (mon_on && !done) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry at %0t", $time);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [N-1:0]        rdy;
        logic                r;
        logic [N-1:0]        v;
        logic [N*REG_W-1:0]  rds;
        logic [N*DATA_W-1:0] ds;

        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            pv[i]       = 1'b0;
            prd[i]      = '0;
            pd[i]       = '0;
        end
        for (int i = 0; i < 2**REG_W; i++) shadow[i] = '0;

        // reset state, including valid requests that must not be accepted
        cycle(1'b1, 3'b000, '0, '0, rdy);
        cycle(1'b1, 3'b111, pack_rd(1, 2, 3), pack_d(1, 2, 3), rdy);

        // single requester
        cycle(1'b0, 3'b010, pack_rd(0, 5, 0), pack_d(0, 'hA5, 0), rdy);
        cycle(1'b0, 3'b000, '0, '0, rdy);
        cycle(1'b0, 3'b000, '0, '0, rdy);

        // all three continuously valid from reset
        cycle(1'b1, 3'b000, '0, '0, rdy);
        repeat (6) cycle(1'b0, 3'b111, pack_rd(1, 2, 3), pack_d(10, 20, 30), rdy);

        // rd=0 discard alongside a grant to the last requester, then wrap
        cycle(1'b1, 3'b000, '0, '0, rdy);
        cycle(1'b0, 3'b101, pack_rd(0, 0, 7), pack_d('h55, 0, 'h77), rdy);
        cycle(1'b0, 3'b111, pack_rd(1, 2, 3), pack_d(10, 20, 30), rdy);

        // same destination from two requesters
        cycle(1'b1, 3'b000, '0, '0, rdy);
        cycle(1'b0, 3'b011, pack_rd(4, 4, 0), pack_d('h11, 'h22, 0), rdy);
        cycle(1'b0, 3'b010, pack_rd(4, 4, 0), pack_d('h11, 'h22, 0), rdy);
        cycle(1'b0, 3'b000, '0, '0, rdy);
        cycle(1'b0, 3'b000, '0, '0, rdy);
        check("regs4_last_write", 64'(shadow[4]), 64'h22);

        // reset while requester 1 is waiting
        cycle(1'b0, 3'b011, pack_rd(1, 2, 0), pack_d('h31, 'h32, 0), rdy);
        cycle(1'b1, 3'b010, pack_rd(1, 2, 0), pack_d('h31, 'h32, 0), rdy);
        cycle(1'b1, 3'b010, pack_rd(1, 2, 0), pack_d('h31, 'h32, 0), rdy);
        cycle(1'b0, 3'b011, pack_rd(1, 2, 0), pack_d('h41, 'h32, 0), rdy);

        // idle
        repeat (10) cycle(1'b0, 3'b000, '0, '0, rdy);

        // randomized traffic; requesters hold until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i]  = 1'b1;
                    prd[i] = REG_W'($urandom_range(0, 7));
                    pd[i]  = DATA_W'($urandom);
                end
            end
            r   = ($urandom_range(0, 49) == 0);
            v   = '0;
            rds = '0;
            ds  = '0;
            for (int i = 0; i < N; i++) begin
                v[i]                    = pv[i];
                rds[i*REG_W +: REG_W]   = prd[i];
                ds[i*DATA_W +: DATA_W]  = pd[i];
            end
            cycle(r, v, rds, ds, rdy);
            for (int i = 0; i < N; i++)
                if (rdy[i]) pv[i] = 1'b0;
        end

        cycle(1'b0, 3'b000, '0, '0, rdy);
        done = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, meaning the number of writeback requesters (ALU, MEM, MUL), legal range 2..8.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  N_REQ  per-requester writeback request.
REQ-005 SHALL have port req_rd  input  N_REQ*`REG_NUM width  packed destination register per requester, requester i at slice i.
REQ-006 SHALL have port req_data  input  N_REQ*`COMMON_WIDTH width  packed writeback data per requester, requester i at slice i.
REQ-007 SHALL have port req_ready  output  N_REQ  combinational accept per requester.
REQ-008 SHALL have port reg_write  output  `REG_NUM  registered destination to id_reg_file; 0 means no write.
REQ-009 SHALL have port data_write  output  `COMMON_WIDTH  registered write data to id_reg_file.

Function
REQ-010 SHALL transfer from requester i exactly when req_valid[i] && req_ready[i] at posedge clk.
REQ-011 SHALL require requesters to hold req_valid, req_rd and req_data stable until transfer; the arbiter SHALL NOT depend on a requester withdrawing.
REQ-012 SHALL assert req_ready[i] in the same cycle for any valid request with req_rd slice == 0, discarding it without consuming the write port.
REQ-013 SHALL grant at most one valid request with nonzero rd per cycle; selection is round-robin starting at pointer ptr, searching ptr, ptr+1, ..., mod N_REQ.
REQ-014 SHALL assert req_ready only for the granted requester among nonzero-rd requests; all others stay 0.
REQ-015 SHALL, on the posedge after a grant to requester g, drive reg_write/data_write with g's rd/data for exactly one cycle (latency 1).
REQ-016 SHALL drive reg_write = 0 and data_write = 0 in any cycle following a cycle with no grant.
REQ-017 SHALL update ptr to (g+1) mod N_REQ after a grant to g; ptr SHALL hold when there is no grant; wrap from N_REQ-1 to 0.
REQ-018 SHALL, while requester i's request stays continuously valid with nonzero rd, grant it within N_REQ cycles (starvation bound).
REQ-019 SHALL, when two requesters target the same rd in one cycle, grant them in round-robin order on separate cycles; the last write issued wins in id_reg_file.
REQ-020 SHALL allow a rd=0 discard and a nonzero-rd grant in the same cycle.
REQ-021 SHALL have no combinational path from req_* to reg_write or data_write.

Reset
REQ-022 SHALL, while rst=1, force req_ready = 0, with reg_write = 0, data_write = 0 and ptr = 0 on the next posedge.
REQ-023 SHALL drop any request pending at reset assertion mid-operation; no write from it appears after reset.
REQ-024 SHALL begin arbitrating on the first posedge after rst deasserts, with ptr = 0.

Structure
REQ-025 SHALL take `REG_NUM, `COMMON_WIDTH and a new `WB_REQ_NUM default from the shared define.h header.
REQ-026 SHALL place the round-robin grant logic in one sub-module, rr_arbiter: inputs are the request vector and ptr; output is a one-hot grant.
REQ-027 SHALL keep ptr and the output registers in wb_arbiter.

Verification
REQ-028 Directed test, single requester: req 1 valid with rd=5, data=0xA5 -> req_ready[1]=1 in the same cycle; next cycle reg_write=5, data_write=0xA5; the cycle after, reg_write=0.
REQ-029 Directed test, all three valid continuously with rd=1/2/3, data=10/20/30, from reset -> grants 0,1,2,0,... ; reg_write sequence 1,2,3; at most 3 cycles between grants to any requester.
REQ-030 Directed test, rd=0 discard: req 0 rd=0 and req 2 rd=7 valid together -> both ready in the same cycle; only reg_write=7 appears; ptr advances to 0 (wrap).
REQ-031 Directed test, same-rd conflict: req 0 and req 1 both rd=4, data 0x11/0x22, ptr=0 -> reg_write=4/0x11, then 4/0x22; DUT.regs[4]=0x22 and modified[4] cleared.
REQ-032 Directed test, reset mid-operation: rst asserted while req 1 is waiting -> req_ready=0, reg_write=0; after release, the first grant goes to requester 0 if it is valid.
REQ-033 Directed test, idle: no valid requests for 10 cycles -> reg_write=0, data_write=0 throughout, and ptr unchanged.
